// File: rtl/riscv_pkg.sv
// Shared types for the unified-memory build of the core: arbiter state,
// port ownership encoding and default bus widths.
package riscv_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arbState_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles of an outstanding memory transaction; expired flags the last
// cycle the memory is given before the transaction is abandoned.
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Holds at LAST so a stalled enable can never wrap back to zero.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one request/response memory between the fetch port and the data port.
// Data wins by default; a streak limit guarantees fetch progress.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err,
  output logic              stall_if,
  output logic              stall_dm
);

  // Handshake: a requester holds req and its operands stable until its done
  // strobe; mem_req/operands are held until mem_gnt; exactly one mem_rvalid
  // is expected per grant and the matching done fires in the same cycle.

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  arbState_e     state;
  owner_e        owner;
  logic [SW-1:0] streak;

  logic isIdle;
  logic isBusy;
  logic streakFull;
  logic dmWins;
  logic ifWins;
  logic grant;
  logic expired;
  logic respDone;
  logic [DATA_W-1:0] respData;

  assign isIdle     = (state == ARB_IDLE);
  assign isBusy     = (state == ARB_BUSY);
  assign streakFull = (streak == STREAK_MAX);

  // Fetch only overtakes a pending data request once data has used its streak.
  assign dmWins = dm_req && !(if_req && streakFull);
  assign ifWins = if_req && !dmWins;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (isIdle && !reset) begin
      if (dmWins) begin
        mem_req   = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else if (ifWins) begin
        mem_req   = 1'b1;
        mem_addr  = if_addr;
      end
    end
  end

  assign grant = mem_req && mem_gnt;

  // A response and the timeout in the same cycle resolve as a normal response.
  assign respDone = isBusy && (mem_rvalid || expired) && !reset;
  assign respData = mem_rvalid ? mem_rdata : '0;

  assign if_done  = respDone && (owner == OWN_IF);
  assign dm_done  = respDone && (owner == OWN_DM);
  assign if_rdata = if_done ? respData : '0;
  assign dm_rdata = dm_done ? respData : '0;
  assign bus_err  = respDone && !mem_rvalid;

  assign stall_if = if_req && !if_done;
  assign stall_dm = dm_req && !dm_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ARB_IDLE;
      owner  <= OWN_IF;
      streak <= '0;
    end else if (isIdle) begin
      if (grant) begin
        state <= ARB_BUSY;
        owner <= dmWins ? OWN_DM : OWN_IF;
        if (dmWins && if_req) begin
          if (!streakFull) begin
            streak <= streak + SW'(1);
          end
        end else begin
          streak <= '0;
        end
      end
    end else begin
      if (mem_rvalid || expired) begin
        state <= ARB_IDLE;
      end
    end
  end

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) timeoutCounter (
    .clock   (clock),
    .reset   (reset),
    .clear   (grant),
    .enable  (isBusy),
    .expired (expired)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-port requester queues, a reactive memory
// model, and a scoreboard of expected grants and responses.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        stall_if;
  logic        stall_dm;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MAX_STREAK (4),
    .TIMEOUT    (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_done    (dm_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .bus_err    (bus_err),
    .stall_if   (stall_if),
    .stall_dm   (stall_dm)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- bench state ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int grantCyc = 0;
  int grantCount = 0;
  int rvDelay = 1;
  int rvCnt = 0;
  int gntStall = 0;
  int startCyc;
  int base;
  logic        prevStalled = 1'b0;
  logic [31:0] prevAddr = 32'h0;
  logic [31:0] pendData = 32'h0;
  logic [41:0] obs;

  logic [31:0] memArr [logic [31:0]];
  logic [64:0] ifJobs[$];
  logic [64:0] dmJobs[$];
  logic [64:0] gntQ[$];
  logic [41:0] expQ[$];

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] patt(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return patt(a);
  endfunction

  task automatic expGrant(input logic we, input logic [31:0] a, input logic [31:0] d);
    gntQ.push_back({we, a, d});
  endtask

  task automatic expResp(input logic port, input logic err, input int lat, input logic [31:0] d);
    expQ.push_back({port, err, 8'(lat), d});
  endtask

  // ---------------- driver ----------------
  task automatic applyJobs();
    if_req = (ifJobs.size() != 0);
    if_addr = 32'h0;
    if (if_req) if_addr = ifJobs[0][63:32];
    dm_req = (dmJobs.size() != 0);
    {dm_we, dm_addr, dm_wdata} = 65'h0;
    if (dm_req) {dm_we, dm_addr, dm_wdata} = dmJobs[0];
  endtask

  task automatic runJobs(input int stopAt, input int budget);
    int n = 0;
    while ((ifJobs.size() != 0 || dmJobs.size() != 0) && n < budget &&
           !(stopAt > 0 && grantCount >= stopAt)) begin
      applyJobs();
      @(posedge clock);
      #2;
      n++;
    end
    if (n >= budget) chk("budget_expired", 72'(1), 72'(0));
    applyJobs();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // ---------------- memory model ----------------
  always @(posedge clock) begin
    #1;
    mem_gnt = (gntStall == 0);
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    if (rvCnt > 0) begin
      rvCnt--;
      if (rvCnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = pendData;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      chk("rst_quiet", 72'({mem_req, if_done, dm_done, bus_err}), 72'(0));
      prevStalled = 1'b0;
    end else begin
      chk("stall_if", 72'(stall_if), 72'(if_req & ~if_done));
      chk("stall_dm", 72'(stall_dm), 72'(dm_req & ~dm_done));
      if (!if_req && !dm_req)
        chk("noreq_drive", 72'({mem_req, mem_we, mem_addr, mem_wdata}), 72'(0));
      if (mem_req && !mem_gnt) begin
        if (prevStalled) chk("hold_addr", 72'(mem_addr), 72'(prevAddr));
        prevStalled = 1'b1;
        prevAddr = mem_addr;
        if (gntStall > 0) gntStall--;
      end else begin
        prevStalled = 1'b0;
      end
      if (mem_req && mem_gnt) begin
        grantCount++;
        grantCyc = cyc;
        if (gntQ.size() == 0) chk("extra_grant", 72'(1), 72'(0));
        else chk("grant", 72'({mem_we, mem_addr, mem_wdata}), 72'(gntQ.pop_front()));
        pendData = mem_we ? 32'h0 : memRead(mem_addr);
        if (mem_we) memArr[mem_addr] = mem_wdata;
        rvCnt = rvDelay;
      end
      if (if_done || dm_done) begin
        obs = {dm_done, bus_err, 8'(cyc - grantCyc), dm_done ? dm_rdata : if_rdata};
        if (expQ.size() == 0) chk("extra_done", 72'(1), 72'(0));
        else chk("resp", 72'(obs), 72'(expQ.pop_front()));
        if (if_done && dm_done) chk("both_done", 72'(1), 72'(0));
        if (if_done && ifJobs.size() != 0) void'(ifJobs.pop_front());
        if (dm_done && dmJobs.size() != 0) void'(dmJobs.pop_front());
      end else if (bus_err) begin
        chk("lone_bus_err", 72'(1), 72'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h1;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    memArr[32'h100] = 32'h00500093;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    applyJobs();
    @(negedge clock);
    chk("post_rst", 72'({mem_req, if_done, dm_done, bus_err, stall_if, stall_dm, mem_addr}), 72'(0));
    @(posedge clock);
    #2;

    // fetch only
    ifJobs.push_back({1'b0, 32'h100, 32'h0});
    expGrant(1'b0, 32'h100, 32'h0);
    expResp(1'b0, 1'b0, 1, 32'h00500093);
    runJobs(0, 100);
    idle(2);

    // simultaneous: data store first, fetch at next idle
    dmJobs.push_back({1'b1, 32'h2000, 32'hDEADBEEF});
    ifJobs.push_back({1'b0, 32'h104, 32'h0});
    expGrant(1'b1, 32'h2000, 32'hDEADBEEF);
    expResp(1'b1, 1'b0, 1, 32'h0);
    expGrant(1'b0, 32'h104, 32'h0);
    expResp(1'b0, 1'b0, 1, patt(32'h104));
    runJobs(0, 100);
    dmJobs.push_back({1'b0, 32'h2000, 32'h0});
    expGrant(1'b0, 32'h2000, 32'h0);
    expResp(1'b1, 1'b0, 1, 32'hDEADBEEF);
    runJobs(0, 100);
    idle(1);

    // starvation limit: DM x4, IF, DM x4, IF, DM x2
    for (int k = 0; k < 10; k++) begin
      dmJobs.push_back({1'b0, 32'h3000 + 32'(4 * k), 32'h0});
      expGrant(1'b0, 32'h3000 + 32'(4 * k), 32'h0);
      expResp(1'b1, 1'b0, 1, patt(32'h3000 + 32'(4 * k)));
      if (k == 3) begin
        expGrant(1'b0, 32'h200, 32'h0);
        expResp(1'b0, 1'b0, 1, patt(32'h200));
      end
      if (k == 7) begin
        expGrant(1'b0, 32'h204, 32'h0);
        expResp(1'b0, 1'b0, 1, patt(32'h204));
      end
    end
    ifJobs.push_back({1'b0, 32'h200, 32'h0});
    ifJobs.push_back({1'b0, 32'h204, 32'h0});
    runJobs(0, 200);
    idle(1);

    // grant backpressure: three refused cycles
    gntStall = 3;
    mem_gnt = 1'b0;
    ifJobs.push_back({1'b0, 32'h108, 32'h0});
    expGrant(1'b0, 32'h108, 32'h0);
    expResp(1'b0, 1'b0, 1, patt(32'h108));
    startCyc = cyc + 1;
    runJobs(0, 100);
    chk("gnt_wait", 72'(grantCyc - startCyc), 72'(3));
    idle(1);

    // timeout with no response, then response exactly on the timeout cycle
    rvDelay = 0;
    dmJobs.push_back({1'b0, 32'h6000, 32'h0});
    expGrant(1'b0, 32'h6000, 32'h0);
    expResp(1'b1, 1'b1, 16, 32'h0);
    runJobs(0, 100);
    rvDelay = 16;
    dmJobs.push_back({1'b0, 32'h6004, 32'h0});
    expGrant(1'b0, 32'h6004, 32'h0);
    expResp(1'b1, 1'b0, 16, patt(32'h6004));
    runJobs(0, 100);
    rvDelay = 1;
    idle(2);

    // reset during BUSY after building a full data streak
    for (int k = 0; k < 4; k++) begin
      dmJobs.push_back({1'b0, 32'h4000 + 32'(4 * k), 32'h0});
      expGrant(1'b0, 32'h4000 + 32'(4 * k), 32'h0);
      if (k < 3) expResp(1'b1, 1'b0, 1, patt(32'h4000 + 32'(4 * k)));
    end
    ifJobs.push_back({1'b0, 32'h300, 32'h0});
    base = grantCount;
    runJobs(base + 3, 100);
    rvDelay = 3;
    runJobs(base + 4, 100);
    reset = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    ifJobs.delete();
    dmJobs.delete();
    applyJobs();
    rvDelay = 1;
    idle(3);
    dmJobs.push_back({1'b0, 32'h5000, 32'h0});
    ifJobs.push_back({1'b0, 32'h304, 32'h0});
    expGrant(1'b0, 32'h5000, 32'h0);
    expResp(1'b1, 1'b0, 1, patt(32'h5000));
    expGrant(1'b0, 32'h304, 32'h0);
    expResp(1'b0, 1'b0, 1, patt(32'h304));
    runJobs(0, 100);
    idle(3);

    chk("gnt_left", 72'(gntQ.size()), 72'(0));
    chk("exp_left", 72'(expQ.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
